// File: rtl/rvh_l1d_snp_ctrl.sv
// L1D snoop responder: looks up the snooped set, downgrades or invalidates
// the hit line through the LST snoop write port, fetches dirty data and
// returns a snoop response. One snoop is handled at a time.
module rvh_l1d_snp_ctrl #(
  parameter int TAG_W  = 20,
  parameter int ID_W   = 4,
  parameter int LINE_W = 512
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 snp_req_valid,
  output logic                 snp_req_ready,
  input  logic [1:0]           snp_req_type,
  input  logic                 snp_req_set_idx,
  input  logic [TAG_W-1:0]     snp_req_tag,
  input  logic [ID_W-1:0]      snp_req_id,
  output logic                 tag_rd_en,
  output logic                 tag_rd_set_idx,
  input  logic [4*TAG_W-1:0]   tag_rd_dat,
  output logic                 lst_rd_idx_snp,
  input  logic [7:0]           lst_rd_dat_snp,
  input  logic                 s0_lst_wr_busy,
  output logic                 lst_mesi_wr_en_snp,
  output logic                 lst_mesi_wr_set_idx_snp,
  output logic [1:0]           lst_mesi_wr_way_idx_snp,
  output logic [1:0]           lst_mesi_wr_dat_snp,
  output logic                 data_rd_valid,
  input  logic                 data_rd_ready,
  output logic                 data_rd_set_idx,
  output logic [1:0]           data_rd_way_idx,
  input  logic                 data_rd_resp_valid,
  input  logic [LINE_W-1:0]    data_rd_resp_dat,
  output logic                 snp_busy,
  output logic                 snp_busy_set_idx,
  output logic                 snp_resp_valid,
  input  logic                 snp_resp_ready,
  output logic [ID_W-1:0]      snp_resp_id,
  output logic                 snp_resp_hit,
  output logic [1:0]           snp_resp_was_state,
  output logic                 snp_resp_has_data,
  output logic [LINE_W-1:0]    snp_resp_dat
);

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_M = 2'd3;
  localparam logic [1:0] SNP_SHARED = 2'd0;
  localparam logic [1:0] SNP_INV    = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECIDE, ST_DATA_REQ, ST_DATA_WAIT, ST_LST_WR, ST_RESP
  } state_e;

  state_e state_reg, state_next;

  logic [1:0]        type_reg;
  logic              set_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [ID_W-1:0]   id_reg;
  logic              hit_reg;
  logic [1:0]        way_reg;
  logic [1:0]        old_reg;
  logic [1:0]        new_reg;
  logic              need_data_reg;
  logic              need_wr_reg;
  logic [LINE_W-1:0] data_reg;

  logic [3:0] way_match;
  logic       dec_hit;
  logic [1:0] dec_way;
  logic [1:0] dec_old;
  logic [1:0] dec_new;
  logic       dec_need_data;
  logic       dec_need_wr;

  // Per-way hit: tag equal and line not Invalid
  for (genvar gi = 0; gi < 4; gi++) begin : g_way
    assign way_match[gi] = (tag_rd_dat[gi*TAG_W +: TAG_W] == tag_reg) &&
                           (lst_rd_dat_snp[2*gi +: 2] != MESI_I);
  end

  // Lowest matching way wins; derive the new state and what work is needed
  always_comb begin
    dec_hit = |way_match;
    dec_way = 2'd0;
    dec_old = MESI_I;
    for (int w = 3; w >= 0; w--) begin
      if (way_match[w]) begin
        dec_way = w[1:0];
        dec_old = lst_rd_dat_snp[2*w +: 2];
      end
    end
    case (type_reg)
      SNP_SHARED: dec_new = (dec_old == MESI_I) ? MESI_I : MESI_S;
      SNP_INV:    dec_new = MESI_I;
      default:    dec_new = dec_old;
    endcase
    dec_need_data = dec_hit && (dec_old == MESI_M);
    dec_need_wr   = (dec_new != dec_old);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_next         = state_reg;
    snp_req_ready      = 1'b0;
    tag_rd_en          = 1'b0;
    tag_rd_set_idx     = 1'b0;
    data_rd_valid      = 1'b0;
    lst_mesi_wr_en_snp = 1'b0;
    snp_resp_valid     = 1'b0;
    snp_busy           = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        snp_busy      = 1'b0;
        snp_req_ready = 1'b1;
        if (snp_req_valid) begin
          tag_rd_en      = 1'b1;
          tag_rd_set_idx = snp_req_set_idx;
          state_next     = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (dec_need_data)    state_next = ST_DATA_REQ;
        else if (dec_need_wr) state_next = ST_LST_WR;
        else                  state_next = ST_RESP;
      end
      ST_DATA_REQ: begin
        data_rd_valid = 1'b1;
        if (data_rd_ready) state_next = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: begin
        if (data_rd_resp_valid) state_next = need_wr_reg ? ST_LST_WR : ST_RESP;
      end
      ST_LST_WR: begin
        // the s0 pipeline owns the LST write port whenever it is busy
        if (!s0_lst_wr_busy) begin
          lst_mesi_wr_en_snp = 1'b1;
          state_next         = ST_RESP;
        end
      end
      ST_RESP: begin
        snp_resp_valid = 1'b1;
        if (snp_resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch request fields on accept, lookup result in DECIDE, data on return
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      type_reg      <= 2'd0;
      set_reg       <= 1'b0;
      tag_reg       <= '0;
      id_reg        <= '0;
      hit_reg       <= 1'b0;
      way_reg       <= 2'd0;
      old_reg       <= MESI_I;
      new_reg       <= MESI_I;
      need_data_reg <= 1'b0;
      need_wr_reg   <= 1'b0;
      data_reg      <= '0;
    end else begin
      if (state_reg == ST_IDLE && snp_req_valid) begin
        type_reg      <= snp_req_type;
        set_reg       <= snp_req_set_idx;
        tag_reg       <= snp_req_tag;
        id_reg        <= snp_req_id;
        hit_reg       <= 1'b0;
        way_reg       <= 2'd0;
        old_reg       <= MESI_I;
        new_reg       <= MESI_I;
        need_data_reg <= 1'b0;
        need_wr_reg   <= 1'b0;
        data_reg      <= '0;
      end
      if (state_reg == ST_DECIDE) begin
        hit_reg       <= dec_hit;
        way_reg       <= dec_way;
        old_reg       <= dec_old;
        new_reg       <= dec_new;
        need_data_reg <= dec_need_data;
        need_wr_reg   <= dec_need_wr;
      end
      if (state_reg == ST_DATA_WAIT && data_rd_resp_valid) begin
        data_reg <= data_rd_resp_dat;
      end
    end
  end

  assign lst_rd_idx_snp          = set_reg;
  assign lst_mesi_wr_set_idx_snp = set_reg;
  assign lst_mesi_wr_way_idx_snp = way_reg;
  assign lst_mesi_wr_dat_snp     = new_reg;
  assign data_rd_set_idx         = set_reg;
  assign data_rd_way_idx         = way_reg;
  assign snp_busy_set_idx        = set_reg;
  assign snp_resp_id             = id_reg;
  assign snp_resp_hit            = hit_reg;
  assign snp_resp_was_state      = old_reg;
  assign snp_resp_has_data       = need_data_reg;
  assign snp_resp_dat            = data_reg;

  // need_data_reg doubles as has_data; keep it consistent with the old state
  logic unused_ok;
  assign unused_ok = ^{old_reg == MESI_M};

endmodule

// File: tb/tb_rvh_l1d_snp_ctrl.sv
// Scoreboard bench for rvh_l1d_snp_ctrl: directed snoops push expected
// responses and LST writes; monitors compare whatever the DUT presents.
module tb_rvh_l1d_snp_ctrl;
  localparam int TAG_W  = 20;
  localparam int ID_W   = 4;
  localparam int LINE_W = 512;

  logic clk = 1'b0;
  logic rstn;
  logic snp_req_valid, snp_req_ready;
  logic [1:0] snp_req_type;
  logic snp_req_set_idx;
  logic [TAG_W-1:0] snp_req_tag;
  logic [ID_W-1:0] snp_req_id;
  logic tag_rd_en, tag_rd_set_idx;
  logic [4*TAG_W-1:0] tag_rd_dat = '0;
  logic lst_rd_idx_snp;
  logic [7:0] lst_rd_dat_snp;
  logic s0_lst_wr_busy;
  logic lst_mesi_wr_en_snp, lst_mesi_wr_set_idx_snp;
  logic [1:0] lst_mesi_wr_way_idx_snp, lst_mesi_wr_dat_snp;
  logic data_rd_valid, data_rd_ready;
  logic data_rd_set_idx;
  logic [1:0] data_rd_way_idx;
  logic data_rd_resp_valid;
  logic [LINE_W-1:0] data_rd_resp_dat;
  logic snp_busy, snp_busy_set_idx;
  logic snp_resp_valid, snp_resp_ready;
  logic [ID_W-1:0] snp_resp_id;
  logic snp_resp_hit;
  logic [1:0] snp_resp_was_state;
  logic snp_resp_has_data;
  logic [LINE_W-1:0] snp_resp_dat;

  rvh_l1d_snp_ctrl #(.TAG_W(TAG_W), .ID_W(ID_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rstn(rstn),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_type(snp_req_type), .snp_req_set_idx(snp_req_set_idx),
    .snp_req_tag(snp_req_tag), .snp_req_id(snp_req_id),
    .tag_rd_en(tag_rd_en), .tag_rd_set_idx(tag_rd_set_idx), .tag_rd_dat(tag_rd_dat),
    .lst_rd_idx_snp(lst_rd_idx_snp), .lst_rd_dat_snp(lst_rd_dat_snp),
    .s0_lst_wr_busy(s0_lst_wr_busy),
    .lst_mesi_wr_en_snp(lst_mesi_wr_en_snp), .lst_mesi_wr_set_idx_snp(lst_mesi_wr_set_idx_snp),
    .lst_mesi_wr_way_idx_snp(lst_mesi_wr_way_idx_snp), .lst_mesi_wr_dat_snp(lst_mesi_wr_dat_snp),
    .data_rd_valid(data_rd_valid), .data_rd_ready(data_rd_ready),
    .data_rd_set_idx(data_rd_set_idx), .data_rd_way_idx(data_rd_way_idx),
    .data_rd_resp_valid(data_rd_resp_valid), .data_rd_resp_dat(data_rd_resp_dat),
    .snp_busy(snp_busy), .snp_busy_set_idx(snp_busy_set_idx),
    .snp_resp_valid(snp_resp_valid), .snp_resp_ready(snp_resp_ready),
    .snp_resp_id(snp_resp_id), .snp_resp_hit(snp_resp_hit),
    .snp_resp_was_state(snp_resp_was_state), .snp_resp_has_data(snp_resp_has_data),
    .snp_resp_dat(snp_resp_dat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tag array (registered read) and LST (combinational read) models
  logic [4*TAG_W-1:0] tag_mem [2];
  logic [7:0] lst_mem [2];
  always @(posedge clk) if (tag_rd_en) tag_rd_dat <= tag_mem[tag_rd_set_idx];
  assign lst_rd_dat_snp = lst_mem[lst_rd_idx_snp];

  typedef struct {
    logic [ID_W-1:0] id; logic hit; logic [1:0] was; logic hd;
    logic [LINE_W-1:0] dat; int lat;
  } resp_t;
  typedef struct { logic set; logic [1:0] way; logic [1:0] dat; int lat; } wr_t;
  resp_t exp_resp[$];
  wr_t   exp_wr[$];

  int asserts = 0;
  int fails = 0;
  int acc_cyc = 0;
  int rd_delay = 0;
  logic data_supp = 1'b0;
  logic [LINE_W-1:0] data_pat = '0;
  logic exp_dset = 1'b0;
  logic [1:0] exp_dway = 2'd0;
  int data_hs_cnt = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // data array model: ready after rd_delay cycles, data one cycle after handshake
  initial begin
    int wcnt;
    logic pend;
    wcnt = 0; pend = 1'b0;
    data_rd_ready = 1'b0; data_rd_resp_valid = 1'b0; data_rd_resp_dat = '0;
    forever begin
      @(negedge clk);
      data_rd_resp_valid = 1'b0;
      data_rd_resp_dat   = '0;
      data_rd_ready      = 1'b0;
      if (!rstn) begin
        pend = 1'b0; wcnt = 0;
      end else begin
        if (pend && !data_supp) begin
          data_rd_resp_valid = 1'b1;
          data_rd_resp_dat   = data_pat;
          pend = 1'b0;
        end
        if (data_rd_valid) begin
          if (wcnt >= rd_delay) begin
            data_rd_ready = 1'b1;
            pend = 1'b1;
            wcnt = 0;
            data_hs_cnt++;
            check("data_rd_set", data_rd_set_idx, exp_dset);
            check("data_rd_way", data_rd_way_idx, exp_dway);
          end else wcnt++;
        end
      end
    end
  end

  // monitor: responses and LST writes against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (snp_resp_valid && snp_resp_ready) begin
          if (exp_resp.size() == 0) begin
            asserts++; fails++;
            $display("FAIL resp_unexpected actual id=%0d required=none", snp_resp_id);
          end else begin
            resp_t e;
            e = exp_resp.pop_front();
            $display("resp id=%0d hit=%0d was=%0d has_data=%0d lat=%0d",
                     snp_resp_id, snp_resp_hit, snp_resp_was_state, snp_resp_has_data, cyc - acc_cyc);
            check("resp_id", snp_resp_id, e.id);
            check("resp_hit", snp_resp_hit, e.hit);
            check("resp_was", snp_resp_was_state, e.was);
            check("resp_has_data", snp_resp_has_data, e.hd);
            check("resp_dat", snp_resp_dat, e.dat);
            check("resp_lat", cyc - acc_cyc, e.lat);
          end
        end
        if (lst_mesi_wr_en_snp) begin
          check("wr_vs_busy", s0_lst_wr_busy, 1'b0);
          if (exp_wr.size() == 0) begin
            asserts++; fails++;
            $display("FAIL wr_unexpected actual set=%0d way=%0d required=none",
                     lst_mesi_wr_set_idx_snp, lst_mesi_wr_way_idx_snp);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            $display("lst_wr set=%0d way=%0d dat=%0d lat=%0d", lst_mesi_wr_set_idx_snp,
                     lst_mesi_wr_way_idx_snp, lst_mesi_wr_dat_snp, cyc - acc_cyc);
            check("wr_set", lst_mesi_wr_set_idx_snp, w.set);
            check("wr_way", lst_mesi_wr_way_idx_snp, w.way);
            check("wr_dat", lst_mesi_wr_dat_snp, w.dat);
            check("wr_lat", cyc - acc_cyc, w.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic s, input logic [TAG_W-1:0] tg, input logic [ID_W-1:0] id);
    int n;
    @(negedge clk);
    snp_req_valid = 1'b1; snp_req_type = t; snp_req_set_idx = s;
    snp_req_tag = tg; snp_req_id = id;
    n = 0;
    while (!snp_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!snp_req_ready) begin
      asserts++; fails++;
      $display("FAIL accept_timeout actual ready=0 required=1");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    snp_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && (exp_resp.size() != 0 || exp_wr.size() != 0 || snp_busy)) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      asserts++; fails++;
      $display("FAIL drain_timeout actual pending=%0d required=0", exp_resp.size() + exp_wr.size());
    end
    @(negedge clk);
  endtask

  task automatic push_resp(input logic [ID_W-1:0] id, input logic hit, input logic [1:0] was,
                           input logic hd, input logic [LINE_W-1:0] dat, input int lat);
    resp_t e;
    e.id = id; e.hit = hit; e.was = was; e.hd = hd; e.dat = dat; e.lat = lat;
    exp_resp.push_back(e);
  endtask

  task automatic push_wr(input logic s, input logic [1:0] way, input logic [1:0] dat, input int lat);
    wr_t w;
    w.set = s; w.way = way; w.dat = dat; w.lat = lat;
    exp_wr.push_back(w);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, snp_req_ready, 1'b1);
    check({tag, "_busy"}, snp_busy, 1'b0);
    check({tag, "_busy_set"}, snp_busy_set_idx, 1'b0);
    check({tag, "_resp_valid"}, snp_resp_valid, 1'b0);
    check({tag, "_wr_en"}, lst_mesi_wr_en_snp, 1'b0);
    check({tag, "_data_rd_valid"}, data_rd_valid, 1'b0);
    check({tag, "_tag_rd_en"}, tag_rd_en, 1'b0);
    check({tag, "_resp_dat"}, snp_resp_dat, '0);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_5a, pat_3c;
    int h0, n;
    pat_a5 = {64{8'hA5}}; pat_5a = {64{8'h5A}}; pat_3c = {64{8'h3C}};
    rstn = 1'b0; snp_req_valid = 1'b0; snp_req_type = 2'd0; snp_req_set_idx = 1'b0;
    snp_req_tag = '0; snp_req_id = '0; s0_lst_wr_busy = 1'b0; snp_resp_ready = 1'b1;
    tag_mem[0] = {20'h400, 20'h300, 20'h200, 20'h100};
    tag_mem[1] = {20'h444, 20'h333, 20'h222, 20'h111};
    lst_mem[0] = 8'h00; lst_mem[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // miss, SNP_INV
    lst_mem[0] = 8'h20;
    push_resp(4'd1, 1'b0, 2'd0, 1'b0, '0, 2);
    issue(2'd1, 1'b0, 20'h999, 4'd1);
    drain();

    // E hit way 2, SNP_SHARED -> S
    push_wr(1'b0, 2'd2, 2'd1, 2);
    push_resp(4'd2, 1'b1, 2'd2, 1'b0, '0, 3);
    issue(2'd0, 1'b0, 20'h300, 4'd2);
    drain();

    // M hit way 1, SNP_INV, data ready delayed 3 cycles
    lst_mem[1] = 8'h0C; rd_delay = 3; data_pat = pat_a5; exp_dset = 1'b1; exp_dway = 2'd1;
    push_wr(1'b1, 2'd1, 2'd0, 7);
    push_resp(4'd3, 1'b1, 2'd3, 1'b1, pat_a5, 8);
    issue(2'd1, 1'b1, 20'h222, 4'd3);
    drain();

    // S hit: PROBE, SHARED and type 3 leave the line alone
    lst_mem[0] = 8'h01;
    push_resp(4'd4, 1'b1, 2'd1, 1'b0, '0, 2);
    issue(2'd2, 1'b0, 20'h100, 4'd4);
    drain();
    push_resp(4'd5, 1'b1, 2'd1, 1'b0, '0, 2);
    issue(2'd0, 1'b0, 20'h100, 4'd5);
    drain();
    push_resp(4'd6, 1'b1, 2'd1, 1'b0, '0, 2);
    issue(2'd3, 1'b0, 20'h100, 4'd6);
    drain();

    // E hit way 3, SNP_INV, s0 holds the LST port for 4 cycles
    lst_mem[1] = 8'h80;
    push_wr(1'b1, 2'd3, 2'd0, 5);
    push_resp(4'd7, 1'b1, 2'd2, 1'b0, '0, 6);
    issue(2'd1, 1'b1, 20'h444, 4'd7);
    s0_lst_wr_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1 s0_lst_wr_busy = 1'b0;
    drain();

    // M hit PROBE: data returned, no LST write
    lst_mem[0] = 8'hC0; rd_delay = 0; data_pat = pat_5a; exp_dset = 1'b0; exp_dway = 2'd3;
    push_resp(4'd8, 1'b1, 2'd3, 1'b1, pat_5a, 4);
    issue(2'd2, 1'b0, 20'h400, 4'd8);
    drain();

    // several tag matches: invalid way 0 skipped, way 1 (M) wins over way 2 (S)
    tag_mem[1] = {20'h444, 20'h777, 20'h777, 20'h777};
    lst_mem[1] = 8'h1C; rd_delay = 1; data_pat = pat_3c; exp_dset = 1'b1; exp_dway = 2'd1;
    push_wr(1'b1, 2'd1, 2'd1, 5);
    push_resp(4'd10, 1'b1, 2'd3, 1'b1, pat_3c, 6);
    issue(2'd0, 1'b1, 20'h777, 4'd10);
    drain();

    // reset while waiting for line data: abort, no response, no write
    tag_mem[1] = {20'h444, 20'h333, 20'h222, 20'h555};
    lst_mem[1] = 8'h03; rd_delay = 0; data_supp = 1'b1; data_pat = pat_a5; exp_dway = 2'd0;
    h0 = data_hs_cnt;
    issue(2'd1, 1'b1, 20'h555, 4'd9);
    n = 0;
    while (data_hs_cnt == h0 && n < 50) begin @(negedge clk); n++; end
    check("reset_test_data_hs", data_hs_cnt != h0, 1'b1);
    @(negedge clk);
    check("dw_busy_before_reset", snp_busy, 1'b1);
    rstn = 1'b0;
    #1 check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    data_supp = 1'b0;
    repeat (3) @(negedge clk);

    // normal snoop after reset: E way 0 SHARED
    lst_mem[1] = 8'h02;
    push_wr(1'b1, 2'd0, 2'd1, 2);
    push_resp(4'd11, 1'b1, 2'd2, 1'b0, '0, 3);
    issue(2'd0, 1'b1, 20'h555, 4'd11);
    drain();
    repeat (5) @(negedge clk);
    check("final_resp_queue", exp_resp.size(), 0);
    check("final_wr_queue", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
